drink_reminder: RTL

Consumer of the debounced 4-bit water level produced by the water-level checker. Tracks the bottle level, detects drinks (level drops) and refills (level rises), and raises a reminder output with a pulsing buzzer when no drink is seen for a programmable interval. It also flags an empty bottle and counts drinks since reset. It sits between the checker and the board LED/buzzer GPIO.

---
 rtl/drink_reminder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/drink_reminder.sv
// Drink reminder: follows the debounced bottle level, counts drinks, flags an
// empty bottle and raises a pulsing reminder after a programmable idle interval.
module drink_reminder #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned REMIND_SECS = 1800,
    parameter int unsigned DRINK_STEP  = 1,
    parameter int unsigned EMPTY_LEVEL = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] water_level,
    input  logic       ack,
    output logic       remind,
    output logic       buzzer,
    output logic       refill,
    output logic [7:0] drink_count
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(TICK_DIV - 1);
    localparam logic [15:0]      SECS_LAST = 16'(REMIND_SECS - 1);
    // Thresholds widened to 5 bits so out-of-range parameters saturate instead of wrapping.
    localparam logic [4:0]       STEP_LVL  = (DRINK_STEP  > 16) ? 5'd16 : 5'(DRINK_STEP);
    localparam logic [4:0]       EMPTY_LVL = (EMPTY_LEVEL > 16) ? 5'd16 : 5'(EMPTY_LEVEL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNTING,
        S_REMINDING,
        S_REFILL
    } state_t;

    state_t           r_state;
    logic [PRE_W-1:0] r_pre;
    logic [15:0]      r_secs;
    logic [3:0]       r_ref;
    logic [7:0]       r_count;
    logic             r_remind;
    logic             r_buzzer;
    logic             r_refill;

    state_t           w_state_nxt;
    logic [PRE_W-1:0] w_pre_nxt;
    logic [15:0]      w_secs_nxt;
    logic [3:0]       w_ref_nxt;
    logic [3:0]       w_drop;
    logic             w_count_inc;
    logic             w_buzzer_nxt;
    logic             w_tick;
    logic             w_empty;
    logic             w_drink;
    logic             w_rise;

    assign w_tick  = (r_pre == PRE_MAX);
    assign w_empty = ({1'b0, water_level} <= EMPTY_LVL);
    assign w_drop  = r_ref - water_level;
    assign w_drink = (water_level < r_ref) && ({1'b0, w_drop} >= STEP_LVL);
    assign w_rise  = (water_level > r_ref);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        w_state_nxt  = r_state;
        w_pre_nxt    = w_tick ? '0 : r_pre + 1'b1;
        w_secs_nxt   = r_secs;
        w_ref_nxt    = r_ref;
        w_count_inc  = 1'b0;
        w_buzzer_nxt = r_buzzer;

        unique case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_ref_nxt   = water_level;
                    w_secs_nxt  = '0;
                    w_state_nxt = w_empty ? S_REFILL : S_COUNTING;
                end
            end

            S_COUNTING: begin
                if (w_empty) begin
                    w_state_nxt = S_REFILL;
                    w_ref_nxt   = water_level;
                    w_pre_nxt   = '0;
                    w_secs_nxt  = '0;
                    w_count_inc = w_drink;
                end else if (w_drink || ack || w_rise) begin
                    w_ref_nxt   = water_level;
                    w_pre_nxt   = '0;
                    w_secs_nxt  = '0;
                    w_count_inc = w_drink;
                end else if (w_tick) begin
                    if (r_secs == SECS_LAST) begin
                        w_state_nxt  = S_REMINDING;
                        w_buzzer_nxt = 1'b1;
                    end else begin
                        w_secs_nxt = r_secs + 16'd1;
                    end
                end
            end

            S_REMINDING: begin
                if (w_tick) begin
                    w_buzzer_nxt = ~r_buzzer;
                end
                if (w_empty) begin
                    w_state_nxt = S_REFILL;
                    w_ref_nxt   = water_level;
                    w_pre_nxt   = '0;
                    w_secs_nxt  = '0;
                    w_count_inc = w_drink;
                end else if (w_drink || ack) begin
                    w_state_nxt = S_COUNTING;
                    w_ref_nxt   = water_level;
                    w_pre_nxt   = '0;
                    w_secs_nxt  = '0;
                    w_count_inc = w_drink;
                end else if (w_rise) begin
                    w_ref_nxt = water_level;
                end
            end

            S_REFILL: begin
                w_pre_nxt  = '0;
                w_secs_nxt = '0;
                if (!w_empty) begin
                    w_state_nxt = S_COUNTING;
                    w_ref_nxt   = water_level;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pre    <= '0;
            r_secs   <= '0;
            r_ref    <= '0;
            r_count  <= '0;
            r_remind <= 1'b0;
            r_buzzer <= 1'b0;
            r_refill <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
            r_state  <= w_state_nxt;
            r_pre    <= w_pre_nxt;
            r_secs   <= w_secs_nxt;
            r_ref    <= w_ref_nxt;
            if (w_count_inc && (r_count != 8'hFF)) begin
                r_count <= r_count + 8'd1;
            end
            r_remind <= (w_state_nxt == S_REMINDING);
            r_buzzer <= (w_state_nxt == S_REMINDING) && w_buzzer_nxt;
            r_refill <= (w_state_nxt == S_REFILL);
        end
    end

    assign remind      = r_remind;
    assign buzzer      = r_buzzer;
    assign refill      = r_refill;
    assign drink_count = r_count;

endmodule
